// File: rtl/mmio_pwm_led_pkg.sv
// Shared definitions for the memory-mapped PWM LED peripheral:
// register word indices, CTRL/STATUS bit positions and the CTRL struct.
package mmio_pwm_led_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_DUTY_LED = 3'd3;
    localparam logic [2:0] REG_DUTY_R   = 3'd4;
    localparam logic [2:0] REG_DUTY_G   = 3'd5;
    localparam logic [2:0] REG_DUTY_B   = 3'd6;
    localparam logic [2:0] REG_STATUS   = 3'd7;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_LED_EN    = 1;
    localparam int CTRL_RGB_EN    = 2;
    localparam int CTRL_IRQ_EN    = 3;

    localparam int STATUS_WRAP    = 0;
    localparam int STATUS_PENDING = 1;

    // Channel order: LED, R, G, B
    localparam int NUM_CH = 4;

    typedef struct packed {
        logic irq_en;
        logic rgb_en;
        logic led_en;
        logic enable;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
        ctrl_t c;
        c.enable = w[CTRL_ENABLE];
        c.led_en = w[CTRL_LED_EN];
        c.rgb_en = w[CTRL_RGB_EN];
        c.irq_en = w[CTRL_IRQ_EN];
        return c;
    endfunction

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_ENABLE] = c.enable;
        w[CTRL_LED_EN] = c.led_en;
        w[CTRL_RGB_EN] = c.rgb_en;
        w[CTRL_IRQ_EN] = c.irq_en;
        return w;
    endfunction

endpackage

// File: rtl/mmio_pwm_led_pwm_channel.sv
// One PWM channel: active duty register that reloads from the shadow
// copy on request, a compare against the shared period counter and a
// registered, polarity-adjusted output pin.
module mmio_pwm_led_pwm_channel #(
    parameter int PWM_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [PWM_W-1:0] i_shadow,
    input  logic [PWM_W-1:0] i_cnt,
    output logic [PWM_W-1:0] o_duty,
    output logic             o_pin
);

    logic [PWM_W-1:0] r_duty;
    logic             r_pin;
    logic             w_on;

    // A duty of 0 never beats the counter; a duty above PERIOD always does.
    assign w_on = i_en & (i_cnt < r_duty);

    // Active duty reload and registered pin; idle level is the unlit level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_duty <= '0;
            r_pin  <= ACTIVE_LOW;
        end else begin
            if (i_load) begin
                r_duty <= i_shadow;
            end
            r_pin <= w_on ^ ACTIVE_LOW;
        end
    end

    assign o_duty = r_duty;
    assign o_pin  = r_pin;

endmodule

// File: rtl/mmio_pwm_led.sv
// Memory-mapped PWM peripheral: register file with bus decode, prescaler,
// period counter and four double-buffered PWM channels (LED, R, G, B).
module mmio_pwm_led
    import mmio_pwm_led_pkg::*;
#(
    parameter int PWM_W          = 8,
    parameter int PRESC_W        = 16,
    parameter bit RGB_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_irq,
    output logic        o_led,
    output logic        o_rgb_r,
    output logic        o_rgb_g,
    output logic        o_rgb_b
);

    ctrl_t              r_ctrl;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [PWM_W-1:0]   r_period;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [PWM_W-1:0]   r_shadow [NUM_CH];
    logic               r_wrap;
    logic [31:0]        r_rdata;
    logic               r_rvalid;

    logic [2:0]         w_idx;
    logic               w_wr;
    logic               w_rd;
    logic               w_tick;
    logic               w_wrap;
    logic               w_load;
    logic               w_led_on;
    logic               w_rgb_on;
    logic               w_pending;
    logic [PWM_W-1:0]   w_shadow_nxt [NUM_CH];
    logic [PWM_W-1:0]   w_duty_act [NUM_CH];
    logic [NUM_CH-1:0]  w_pin;
    logic [31:0]        w_rd_val;
    logic               w_unused;

    assign w_idx    = i_addr[4:2];
    assign w_wr     = i_sel & i_we;
    assign w_rd     = i_sel & ~i_we;
    assign w_unused = ^{i_addr[1:0], i_wdata};

    assign w_tick   = r_ctrl.enable & (r_presc_cnt == r_presc);
    // >= so that shrinking PERIOD below the live count wraps on the next tick
    assign w_wrap   = w_tick & (r_pwm_cnt >= r_period);
    // While disabled the active duties follow the shadows every cycle
    assign w_load   = w_wrap | ~r_ctrl.enable;
    assign w_led_on = r_ctrl.enable & r_ctrl.led_en;
    assign w_rgb_on = r_ctrl.enable & r_ctrl.rgb_en;

    // Next shadow values, so a duty written in the wrap cycle is loaded at once.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
        end
        if (w_wr) begin
            case (w_idx)
                REG_DUTY_LED: w_shadow_nxt[0] = i_wdata[PWM_W-1:0];
                REG_DUTY_R:   w_shadow_nxt[1] = i_wdata[PWM_W-1:0];
                REG_DUTY_G:   w_shadow_nxt[2] = i_wdata[PWM_W-1:0];
                REG_DUTY_B:   w_shadow_nxt[3] = i_wdata[PWM_W-1:0];
                default: ;
            endcase
        end
    end

    // Any shadow that has not yet reached its active copy.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_shadow[i] != w_duty_act[i]) begin
                w_pending = 1'b1;
            end
        end
    end

    // Register writes and the sticky wrap flag (a wrap beats a same-cycle W1C).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl   <= '0;
            r_presc  <= '0;
            r_period <= '1;
            r_wrap   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                case (w_idx)
                    REG_CTRL:     r_ctrl   <= ctrl_from_word(i_wdata);
                    REG_PRESCALE: r_presc  <= i_wdata[PRESC_W-1:0];
                    REG_PERIOD:   r_period <= i_wdata[PWM_W-1:0];
                    default: ;
                endcase
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= w_shadow_nxt[i];
            end
            if (w_wrap) begin
                r_wrap <= 1'b1;
            end else if (w_wr && (w_idx == REG_STATUS) && i_wdata[STATUS_WRAP]) begin
                r_wrap <= 1'b0;
            end
        end
    end

    // Prescaler and period counter, both parked at 0 while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else if (!r_ctrl.enable) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            if (w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + 1'b1;
            end
            if (w_wrap) begin
                r_pwm_cnt <= '0;
            end else if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
        end
    end

    // Read mux; unused bits read as zero.
    always_comb begin
        w_rd_val = '0;
        case (w_idx)
            REG_CTRL:     w_rd_val = ctrl_to_word(r_ctrl);
            REG_PRESCALE: w_rd_val[PRESC_W-1:0] = r_presc;
            REG_PERIOD:   w_rd_val[PWM_W-1:0]   = r_period;
            REG_DUTY_LED: w_rd_val[PWM_W-1:0]   = r_shadow[0];
            REG_DUTY_R:   w_rd_val[PWM_W-1:0]   = r_shadow[1];
            REG_DUTY_G:   w_rd_val[PWM_W-1:0]   = r_shadow[2];
            REG_DUTY_B:   w_rd_val[PWM_W-1:0]   = r_shadow[3];
            REG_STATUS: begin
                w_rd_val[STATUS_WRAP]    = r_wrap;
                w_rd_val[STATUS_PENDING] = w_pending;
            end
            default: ;
        endcase
    end

    // Registered read response; rdata holds between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mmio_pwm_led_pwm_channel #(
            .PWM_W      (PWM_W),
            .ACTIVE_LOW ((g == 0) ? 1'b0 : RGB_ACTIVE_LOW)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_load   (w_load),
            .i_en     ((g == 0) ? w_led_on : w_rgb_on),
            .i_shadow (w_shadow_nxt[g]),
            .i_cnt    (r_pwm_cnt),
            .o_duty   (w_duty_act[g]),
            .o_pin    (w_pin[g])
        );
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_irq    = r_wrap & r_ctrl.irq_en;
    assign o_led    = w_pin[0];
    assign o_rgb_r  = w_pin[1];
    assign o_rgb_g  = w_pin[2];
    assign o_rgb_b  = w_pin[3];

endmodule

// File: tb/tb_mmio_pwm_led.sv
// Self-checking bench for mmio_pwm_led. Expected pin levels and STATUS
// come from a closed-form model: the count after n cycles of running is
// floor(n/(PRESCALE+1)) mod (PERIOD+1), wraps fall every
// (PRESCALE+1)*(PERIOD+1) cycles, and active duties follow the shadow
// value seen at the most recent wrap.
module tb_mmio_pwm_led;

    localparam bit RGB_AL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;
    logic        led;
    logic        rgb_r;
    logic        rgb_g;
    logic        rgb_b;
    logic [3:0]  pins;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // reference model state
    int unsigned en_edge = 0;
    int unsigned dw_edge = 32'hFFFF_FFFF;
    int unsigned clr_edge = 0;
    int unsigned p_m = 0;
    int unsigned per_m = 255;
    int unsigned dold [4];
    int unsigned dnew [4];
    bit          m_en = 1'b0;
    bit          g_led = 1'b0;
    bit          g_rgb = 1'b0;
    bit          m_irq_en = 1'b0;

    assign pins = {rgb_b, rgb_g, rgb_r, led};

    mmio_pwm_led #(
        .PWM_W          (8),
        .PRESC_W        (16),
        .RGB_ACTIVE_LOW (RGB_AL)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sel    (sel),
        .i_we     (we),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_rvalid (rvalid),
        .o_irq    (irq),
        .o_led    (led),
        .o_rgb_r  (rgb_r),
        .o_rgb_g  (rgb_g),
        .o_rgb_b  (rgb_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic int unsigned cnt_after(input int unsigned x);
        int unsigned t;
        t = (x - en_edge) / (p_m + 1);
        return t % (per_m + 1);
    endfunction

    function automatic int unsigned last_wrap(input int unsigned x);
        int unsigned len;
        int unsigned j;
        if (!m_en || x < en_edge) return 0;
        len = (p_m + 1) * (per_m + 1);
        j = (x - en_edge) / len;
        return (j == 0) ? 0 : en_edge + j * len;
    endfunction

    function automatic int unsigned shadow_at(input int ch, input int unsigned x);
        return (x >= dw_edge) ? dnew[ch] : dold[ch];
    endfunction

    function automatic int unsigned active_at(input int ch, input int unsigned x);
        int unsigned w;
        w = last_wrap(x);
        return shadow_at(ch, (w == 0) ? en_edge : w);
    endfunction

    // pins as seen after clock edge k
    function automatic logic [3:0] exp_pins(input int unsigned k);
        logic [3:0] v;
        logic       on;
        v = '0;
        for (int ch = 0; ch < 4; ch++) begin
            on = 1'b0;
            if (m_en && k > en_edge) begin
                on = ((ch == 0) ? g_led : g_rgb) && (cnt_after(k - 1) < active_at(ch, k - 1));
            end
            v[ch] = (ch != 0 && RGB_AL) ? ~on : on;
        end
        return v;
    endfunction

    // STATUS contents after clock edge x
    function automatic logic [31:0] exp_status(input int unsigned x);
        logic [31:0] s;
        int unsigned w;
        s = '0;
        for (int ch = 0; ch < 4; ch++) begin
            if (shadow_at(ch, x) != active_at(ch, x)) s[1] = 1'b1;
        end
        w = last_wrap(x);
        s[0] = (w != 0) && (w >= clr_edge);
        return s;
    endfunction

    // ---------------- bus ----------------
    task automatic bus_write(input int unsigned idx, input logic [31:0] data, output int unsigned edge_o);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = {idx[2:0], 2'($urandom_range(0, 3))};
        wdata = data;
        @(posedge clk);
        #1 edge_o = cyc;
        @(negedge clk);
        sel = 1'b0;
        we  = 1'b0;
    endtask

    task automatic bus_read(input int unsigned idx, output logic [31:0] data, output int unsigned edge_o);
        sel  = 1'b1;
        we   = 1'b0;
        addr = {idx[2:0], 2'($urandom_range(0, 3))};
        @(posedge clk);
        #1 edge_o = cyc;
        @(negedge clk);
        sel  = 1'b0;
        data = rdata;
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read_rvalid idx=%0d: got %b want 1", idx, rvalid);
        end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_pwm(input int unsigned p, input int unsigned per,
                             input int unsigned d0, input int unsigned d1,
                             input int unsigned d2, input int unsigned d3,
                             input logic [3:0] c);
        int unsigned e;
        bus_write(0, 32'h0, e);
        m_en = 1'b0;
        bus_write(1, p, e);
        bus_write(2, per, e);
        bus_write(3, d0, e);
        bus_write(4, d1, e);
        bus_write(5, d2, e);
        bus_write(6, d3, e);
        bus_write(7, 32'h1, e);
        clr_edge = e;
        bus_write(0, {28'h0, c}, e);
        en_edge  = e;
        p_m      = p;
        per_m    = per;
        dold[0]  = d0; dold[1] = d1; dold[2] = d2; dold[3] = d3;
        dnew     = dold;
        dw_edge  = 32'hFFFF_FFFF;
        m_en     = c[0];
        g_led    = c[1];
        g_rgb    = c[2];
        m_irq_en = c[3];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        int unsigned r;
        int unsigned e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== 32'h0 || rvalid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: rdata=%h rvalid=%b irq=%b want 0/0/0", rdata, rvalid, irq);
        end
        checks++;
        if (pins !== 4'b1110) begin
            errors++;
            $display("FAIL reset_pins: got %b want 1110", pins);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_idle: got %b want 0", rvalid);
        end
        bus_read(2, rd, r);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL reset_period: got %h want 000000ff", rd);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_drop: got %b want 0", rvalid);
        end
        // unused bits read back as zero, STATUS[1] not writable
        bus_write(0, 32'hFFFF_FFF0, e);
        bus_write(1, 32'hFFFF_FFFF, e);
        bus_write(3, 32'hFFFF_FFFF, e);
        bus_write(7, 32'hFFFF_FFFE, e);
        bus_read(0, rd, r);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_mask: got %h want 00000000", rd);
        end
        bus_read(1, rd, r);
        checks++;
        if (rd !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL presc_mask: got %h want 0000ffff", rd);
        end
        bus_read(3, rd, r);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL duty_mask: got %h want 000000ff", rd);
        end
        bus_read(7, rd, r);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL status_idle: got %h want 00000000", rd);
        end
    endtask

    task automatic test_basic_pwm();
        logic [3:0]  ep;
        logic [31:0] rd;
        int unsigned r;
        int          highs = 0;
        start_pwm(0, 9, 3, 0, 0, 0, 4'h3);
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            ep = exp_pins(cyc);
            checks++;
            if (pins !== ep) begin
                errors++;
                $display("FAIL basic_pins @%0d: got %b want %b", cyc, pins, ep);
            end
            if (cyc > en_edge + 10 && cyc <= en_edge + 40 && led === 1'b1) highs++;
        end
        checks++;
        if (highs != 9) begin
            errors++;
            $display("FAIL basic_duty: led high %0d of 30 cycles, want 9", highs);
        end
        bus_read(7, rd, r);
        checks++;
        if (rd !== exp_status(r - 1) || rd[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_status: got %h want %h", rd, exp_status(r - 1));
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_irq_masked: got %b want 0", irq);
        end
    endtask

    task automatic test_duty_extremes();
        logic [3:0] ep;
        start_pwm(0, 9, 5, 0, 10, 0, 4'h5);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ep = exp_pins(cyc);
            checks++;
            if (pins !== ep) begin
                errors++;
                $display("FAIL extreme_pins @%0d: got %b want %b", cyc, pins, ep);
            end
            checks++;
            if (rgb_r !== 1'b1 || rgb_g !== 1'b0 || led !== 1'b0) begin
                errors++;
                $display("FAIL extreme_levels @%0d: r=%b g=%b led=%b want 1/0/0", cyc, rgb_r, rgb_g, led);
            end
        end
    endtask

    task automatic test_double_buffer();
        logic [3:0]  ep;
        logic [31:0] rd;
        int unsigned w;
        int unsigned r;
        int          highs = 0;
        start_pwm(0, 9, 3, 0, 0, 0, 4'h3);
        wait_until(en_edge + 14);
        bus_write(3, 32'd7, w);
        dnew[0] = 7;
        dw_edge = w;
        bus_read(7, rd, r);
        checks++;
        if (rd[1] !== 1'b1 || rd !== exp_status(r - 1)) begin
            errors++;
            $display("FAIL dbuf_pending_set: got %h want %h", rd, exp_status(r - 1));
        end
        while (cyc < en_edge + 45) begin
            @(negedge clk);
            ep = exp_pins(cyc);
            checks++;
            if (pins !== ep) begin
                errors++;
                $display("FAIL dbuf_pins @%0d: got %b want %b", cyc, pins, ep);
            end
            if (cyc > en_edge + 30 && cyc <= en_edge + 40 && led === 1'b1) highs++;
        end
        checks++;
        if (highs != 7) begin
            errors++;
            $display("FAIL dbuf_new_duty: led high %0d of 10 cycles, want 7", highs);
        end
        bus_read(7, rd, r);
        checks++;
        if (rd[1] !== 1'b0 || rd !== exp_status(r - 1)) begin
            errors++;
            $display("FAIL dbuf_pending_clear: got %h want %h", rd, exp_status(r - 1));
        end
    endtask

    task automatic test_prescaler();
        logic [3:0]  ep;
        int unsigned d;
        int          highs = 0;
        start_pwm(3, 1, 1, 0, 0, 0, 4'h3);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ep = exp_pins(cyc);
            checks++;
            if (pins !== ep) begin
                errors++;
                $display("FAIL presc_pins @%0d: got %b want %b", cyc, pins, ep);
            end
            if (led === 1'b1) highs++;
        end
        checks++;
        if (highs != 16) begin
            errors++;
            $display("FAIL presc_duty: led high %0d of 32 cycles, want 16", highs);
        end
        wait_until(en_edge + 41);
        checks++;
        if (led !== 1'b1) begin
            errors++;
            $display("FAIL presc_before_disable: got %b want 1", led);
        end
        bus_write(0, 32'h0, d);
        m_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (led !== 1'b0) begin
                errors++;
                $display("FAIL presc_disabled @%0d: got %b want 0", cyc, led);
            end
        end
    endtask

    task automatic test_irq_w1c();
        logic [31:0] rd;
        int unsigned c;
        int unsigned r;
        start_pwm(0, 4, 2, 0, 0, 0, 4'b1011);
        wait_until(en_edge + 4);
        bus_write(7, 32'h1, c);
        clr_edge = c;
        checks++;
        if (c != en_edge + 5 || irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_race: edge=%0d irq=%b want edge %0d irq 1", c - en_edge, irq, 5);
        end
        bus_write(7, 32'h1, c);
        clr_edge = c;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: irq got %b want 0", irq);
        end
        bus_read(7, rd, r);
        checks++;
        if (rd[0] !== 1'b0 || rd !== exp_status(r - 1)) begin
            errors++;
            $display("FAIL w1c_status: got %h want %h", rd, exp_status(r - 1));
        end
        wait_until(en_edge + 10);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_reassert: got %b want 1", irq);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ep;
        logic [3:0]  c;
        logic [31:0] rd;
        int unsigned p, per, len, tw, w, r, ch, v;
        int unsigned d [4];
        for (int t = 0; t < 6; t++) begin
            p   = $urandom_range(0, 2);
            per = $urandom_range(1, 12);
            for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, per + 2);
            c = {1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
            start_pwm(p, per, d[0], d[1], d[2], d[3], c);
            len = (p + 1) * (per + 1);
            tw  = en_edge + $urandom_range(2, len);
            while (cyc + 1 < tw) begin
                @(negedge clk);
                ep = exp_pins(cyc);
                checks++;
                if (pins !== ep) begin
                    errors++;
                    $display("FAIL rand_pins t=%0d @%0d: got %b want %b", t, cyc, pins, ep);
                end
            end
            ch = $urandom_range(0, 3);
            v  = $urandom_range(0, per + 2);
            bus_write(3 + ch, v, w);
            dnew[ch] = v;
            dw_edge  = w;
            while (cyc < en_edge + 3 * len + 4) begin
                @(negedge clk);
                ep = exp_pins(cyc);
                checks++;
                if (pins !== ep) begin
                    errors++;
                    $display("FAIL rand_pins2 t=%0d @%0d: got %b want %b", t, cyc, pins, ep);
                end
            end
            bus_read(7, rd, r);
            checks++;
            if (rd !== exp_status(r - 1)) begin
                errors++;
                $display("FAIL rand_status t=%0d: got %h want %h", t, rd, exp_status(r - 1));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        int unsigned r;
        start_pwm(0, 9, 5, 5, 5, 5, 4'h7);
        bus_read(2, rd, r);
        checks++;
        if (rd !== 32'd9) begin
            errors++;
            $display("FAIL areset_period_pre: got %h want 00000009", rd);
        end
        wait_until(en_edge + 3);
        checks++;
        if (pins !== 4'b0001) begin
            errors++;
            $display("FAIL areset_pre_pins: got %b want 0001", pins);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pins !== 4'b1110 || rdata !== 32'h0 || rvalid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: pins=%b rdata=%h rvalid=%b irq=%b want 1110/0/0/0", pins, rdata, rvalid, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_en  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (pins !== 4'b1110) begin
                errors++;
                $display("FAIL areset_idle @%0d: got %b want 1110", cyc, pins);
            end
        end
        bus_read(0, rd, r);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL areset_ctrl: got %h want 00000000", rd);
        end
        bus_read(2, rd, r);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL areset_period: got %h want 000000ff", rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_duty_extremes();
        test_double_buffer();
        test_prescaler();
        test_irq_w1c();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
